// File: rtl/lfsr_rx_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_rx_checker_if
// Serial link between the LFSR generator and the receive-side checker.
//   valid : qualifies data on each rising clock edge
//   data  : serial data bit, LSB of the word first
// Modports:
//   master : the sending side (generator or testbench) drives valid/data
//   slave  : the checker samples valid/data
// ---------------------------------------------------------------------------
interface lfsr_rx_checker_if;
  logic valid;
  logic data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/lfsr_rx_checker.sv
// ---------------------------------------------------------------------------
// lfsr_rx_checker
// Receive end of the LFSR serial link. It deserializes the valid-qualified
// bit stream into a parallel word. In parallel it regenerates the expected
// word from the same seed, with the same taps and step count. It then
// reports a pass/fail verdict for the link.
//
// Parameters:
//   NO_OF_BITS   : LFSR and word width (must be >= 3, taps are bits [2:0])
//   NO_OF_SHIFTS : LFSR steps applied to the seed before serialization
// Ports:
//   i_clk     : clock, all state updates on the rising edge
//   i_rst     : asynchronous active-high reset; the seed is loaded while high
//   i_seed    : seed, must be stable while i_rst is high
//   link      : serial input (valid/data), slave side
//   o_word    : captured word, bit k is the k-th accepted bit
//   o_done    : comparison complete, held until reset
//   o_match   : valid while o_done is high, 1 when o_word equals the expected word
//   o_overrun : sticky, a valid bit arrived after the word was complete
// ---------------------------------------------------------------------------
module lfsr_rx_checker #(
  parameter int NO_OF_BITS   = 4,
  parameter int NO_OF_SHIFTS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NO_OF_BITS-1:0] i_seed,
  lfsr_rx_checker_if.slave      link,
  output logic [NO_OF_BITS-1:0] o_word,
  output logic                  o_done,
  output logic                  o_match,
  output logic                  o_overrun
);

  localparam int GEN_CNT_W = $clog2(NO_OF_SHIFTS + 1);
  localparam int BIT_CNT_W = $clog2(NO_OF_BITS + 1);
  localparam logic [GEN_CNT_W-1:0] GEN_LAST = GEN_CNT_W'(NO_OF_SHIFTS);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(NO_OF_BITS);

  typedef enum logic [1:0] {
    GEN_RX,
    CHECK,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NO_OF_BITS-1:0]   expWord_q, expWord_d;
  logic [GEN_CNT_W-1:0]    genCnt_q, genCnt_d;
  logic [NO_OF_BITS-1:0]   word_q, word_d;
  logic [BIT_CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic                    match_q, match_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    feedback;

  // Generator path: step the local LFSR until the step count is reached,
  // then freeze it. The feedback is the XOR of the three lowest bits and
  // enters at the MSB while the register shifts right.
  assign feedback = ^expWord_q[2:0];

  always_comb begin
    expWord_d = expWord_q;
    genCnt_d  = genCnt_q;
    if (genCnt_q != GEN_LAST) begin
      expWord_d = {feedback, expWord_q[NO_OF_BITS-1:1]};
      genCnt_d  = genCnt_q + 1'b1;
    end
  end

  // Capture path: shift accepted bits in at the MSB so that after a full
  // word the first bit received sits in bit 0. When the word is already
  // complete, a valid bit is dropped and flagged as an overrun. This
  // path runs independently of the generator and the compare FSM.
  always_comb begin
    word_d    = word_q;
    bitCnt_d  = bitCnt_q;
    overrun_d = overrun_q;
    if (link.valid) begin
      if (bitCnt_q != BIT_LAST) begin
        word_d   = {link.data, word_q[NO_OF_BITS-1:1]};
        bitCnt_d = bitCnt_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Compare FSM next-state logic. The FSM waits until both the expected
  // word and the received word are final. It then spends one cycle in
  // CHECK, which registers the verdict, and parks in DONE until reset.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    done_d  = done_q;
    unique case (state_q)
      GEN_RX: begin
        if ((genCnt_q == GEN_LAST) && (bitCnt_q == BIT_LAST)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        match_d = (word_q == expWord_q);
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = GEN_RX;
      end
    endcase
  end

  // All state registers. Reset reloads the expected word from the seed
  // and clears everything else. Any partial word is discarded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= GEN_RX;
      expWord_q <= i_seed;
      genCnt_q  <= '0;
      word_q    <= '0;
      bitCnt_q  <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      expWord_q <= expWord_d;
      genCnt_q  <= genCnt_d;
      word_q    <= word_d;
      bitCnt_q  <= bitCnt_d;
      match_q   <= match_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_word    = word_q;
  assign o_done    = done_q;
  assign o_match   = match_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rx_checker
// Self-checking bench for lfsr_rx_checker with the default parameters
// (4-bit word, 8 generator steps). A table of link scenarios gives, for each
// entry: the seed, the bits to send, when to send them, an optional extra bit
// for overrun, and the expected verdict and done edge. The expected verdict is
// pushed to a scoreboard queue when the last stimulus of a scenario is
// driven. It is popped and compared when the DUT raises o_done. A
// hand-written sequence covers a reset that arrives in the middle of a
// reception.
// ---------------------------------------------------------------------------
module tb_lfsr_rx_checker;

  localparam int N = 4;

  typedef struct {
    string       name;
    logic [3:0]  seed;
    logic [3:0]  bits;       // bit k is the k-th bit sent
    int          startEdge;
    int          gap;        // idle cycles between bits
    logic        hasExtra;
    logic        extraBit;
    logic [3:0]  expWord;
    logic        expMatch;
    logic        expOverrun;
    int          doneEdge;   // o_done first seen high after this edge
  } vec_t;

  typedef struct {
    logic [3:0] word;
    logic       match;
    logic       overrun;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] seed;
  logic [N-1:0] oWord;
  logic         oDone;
  logic         oMatch;
  logic         oOverrun;

  int   assertCount = 0;
  int   failCount   = 0;
  exp_t sbQ[$];
  vec_t vecs[5];

  lfsr_rx_checker_if link ();

  lfsr_rx_checker #(
    .NO_OF_BITS   (4),
    .NO_OF_SHIFTS (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_seed    (seed),
    .link      (link),
    .o_word    (oWord),
    .o_done    (oDone),
    .o_match   (oMatch),
    .o_overrun (oOverrun)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports each failure.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Assert reset asynchronously at a falling edge. Check that all outputs
  // clear at once. Hold reset over two rising edges, then release it at a
  // falling edge so that the next rising edge is edge 1.
  task automatic doReset(input string name, input logic [3:0] s);
    @(negedge clk);
    seed       = s;
    link.valid = 1'b0;
    rst        = 1'b1;
    #1;
    checkOutput({name, "_rst_word"},    32'(oWord),    32'h0);
    checkOutput({name, "_rst_done"},    32'(oDone),    32'h0);
    checkOutput({name, "_rst_match"},   32'(oMatch),   32'h0);
    checkOutput({name, "_rst_overrun"}, 32'(oOverrun), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // After a finished compare, toggle data with valid low. The visible
  // verdict must not move.
  task automatic checkFrozen(input string name, input exp_t e);
    for (int i = 0; i < 10; i++) begin
      link.valid = 1'b0;
      link.data  = i[0];
      @(negedge clk);
    end
    checkOutput({name, "_frozen_word"},  32'(oWord),  32'(e.word));
    checkOutput({name, "_frozen_match"}, 32'(oMatch), 32'(e.match));
    checkOutput({name, "_frozen_done"},  32'(oDone),  32'h1);
  endtask

  // Run one table entry. The entry gives the bit schedule. The scoreboard
  // gets the expected verdict once the last stimulus is driven. The verdict
  // is compared when o_done rises, which must happen on the expected edge.
  task automatic applyStimulus(input vec_t v);
    int   lastEdge;
    int   extraEdge;
    logic seen;
    exp_t got;
    exp_t e;
    seen      = 1'b0;
    got       = '{word: 4'h0, match: 1'b0, overrun: 1'b0};
    extraEdge = v.startEdge + 4 * (v.gap + 1);
    lastEdge  = v.hasExtra ? extraEdge : v.startEdge + 3 * (v.gap + 1);
    doReset(v.name, v.seed);
    for (int edgeNo = 1; edgeNo <= 40; edgeNo++) begin
      link.valid = 1'b0;
      link.data  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if (edgeNo == v.startEdge + k * (v.gap + 1)) begin
          link.valid = 1'b1;
          link.data  = v.bits[k];
        end
      end
      if (v.hasExtra && edgeNo == extraEdge) begin
        link.valid = 1'b1;
        link.data  = v.extraBit;
      end
      if (edgeNo == lastEdge) begin
        e.word    = v.expWord;
        e.match   = v.expMatch;
        e.overrun = v.expOverrun;
        sbQ.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (edgeNo == v.doneEdge - 1) begin
        checkOutput({v.name, "_done_early"}, 32'(oDone), 32'h0);
      end
      if (oDone && !seen) begin
        seen = 1'b1;
        checkOutput({v.name, "_done_edge"}, 32'(edgeNo), 32'(v.doneEdge));
        if (sbQ.size() == 0) begin
          checkOutput({v.name, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
          got = sbQ.pop_front();
          checkOutput({v.name, "_word"},    32'(oWord),    32'(got.word));
          checkOutput({v.name, "_match"},   32'(oMatch),   32'(got.match));
          checkOutput({v.name, "_overrun"}, 32'(oOverrun), 32'(got.overrun));
        end
      end
      if (seen && edgeNo >= lastEdge) break;
    end
    link.valid = 1'b0;
    if (!seen) begin
      checkOutput({v.name, "_done_timeout"}, 32'h0, 32'h1);
      sbQ.delete();
    end else begin
      checkFrozen(v.name, got);
    end
  endtask

  // Reset in the middle of a reception. Two bits arrive, then reset
  // clears the partial word. A full correct word then still matches.
  task automatic runResetMid();
    exp_t e;
    exp_t got;
    logic seen;
    logic [3:0] bits;
    seen = 1'b0;
    got  = '{word: 4'h0, match: 1'b0, overrun: 1'b0};
    bits = 4'b1100;
    doReset("rstmid", 4'b1001);
    link.valid = 1'b1; link.data = 1'b1;
    @(negedge clk);
    link.valid = 1'b1; link.data = 1'b0;
    @(negedge clk);
    link.valid = 1'b0;
    checkOutput("rstmid_partial_word", 32'(oWord), 32'h4);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_word_cleared", 32'(oWord), 32'h0);
    checkOutput("rstmid_done_cleared", 32'(oDone), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int edgeNo = 1; edgeNo <= 30; edgeNo++) begin
      link.valid = (edgeNo <= 4);
      link.data  = (edgeNo <= 4) ? bits[edgeNo-1] : 1'b0;
      if (edgeNo == 4) begin
        e = '{word: 4'b1100, match: 1'b1, overrun: 1'b0};
        sbQ.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (oDone) begin
        seen = 1'b1;
        checkOutput("rstmid_done_edge", 32'(edgeNo), 32'd10);
        if (sbQ.size() == 0) begin
          checkOutput("rstmid_sb_empty", 32'h0, 32'h1);
        end else begin
          got = sbQ.pop_front();
          checkOutput("rstmid_word",    32'(oWord),    32'(got.word));
          checkOutput("rstmid_match",   32'(oMatch),   32'(got.match));
          checkOutput("rstmid_overrun", 32'(oOverrun), 32'(got.overrun));
        end
        break;
      end
    end
    link.valid = 1'b0;
    if (!seen) begin
      checkOutput("rstmid_done_timeout", 32'h0, 32'h1);
      sbQ.delete();
    end
  endtask

  initial begin
    rst        = 1'b1;
    seed       = 4'b0000;
    link.valid = 1'b0;
    link.data  = 1'b0;

    // The seed 1001 stepped 8 times gives 1100. Seeds 1111 and 0000 are
    // fixed points of this LFSR.
    vecs[0] = '{name: "match_gen",   seed: 4'b1001, bits: 4'b1100, startEdge: 10, gap: 0,
                hasExtra: 1'b0, extraBit: 1'b0, expWord: 4'b1100, expMatch: 1'b1,
                expOverrun: 1'b0, doneEdge: 15};
    vecs[1] = '{name: "mismatch",    seed: 4'b1001, bits: 4'b1101, startEdge: 10, gap: 0,
                hasExtra: 1'b0, extraBit: 1'b0, expWord: 4'b1101, expMatch: 1'b0,
                expOverrun: 1'b0, doneEdge: 15};
    vecs[2] = '{name: "early",       seed: 4'b1111, bits: 4'b1111, startEdge: 1,  gap: 0,
                hasExtra: 1'b0, extraBit: 1'b0, expWord: 4'b1111, expMatch: 1'b1,
                expOverrun: 1'b0, doneEdge: 10};
    vecs[3] = '{name: "gap_overrun", seed: 4'b0000, bits: 4'b0000, startEdge: 1,  gap: 1,
                hasExtra: 1'b1, extraBit: 1'b1, expWord: 4'b0000, expMatch: 1'b1,
                expOverrun: 1'b1, doneEdge: 10};
    vecs[4] = '{name: "ovr_at_check", seed: 4'b1001, bits: 4'b1100, startEdge: 10, gap: 0,
                hasExtra: 1'b1, extraBit: 1'b0, expWord: 4'b1100, expMatch: 1'b1,
                expOverrun: 1'b1, doneEdge: 15};

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end
    runResetMid();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/lfsr_rx_checker.md
# lfsr_rx_checker

- Receive end of the LFSR serial link: deserializes the valid-qualified bit stream produced by the `lfsr` generator into a parallel word.
- In parallel, regenerates the expected word locally from the same seed, using the same taps and step count.
- Reports done, match and overrun status.
- Sits next to the generator in self-test / BIST paths and provides the pass/fail verdict for the link.

## Interface

- `NO_OF_BITS`, 4, LFSR and word width; must be ≥ 3 because the taps are bits [2:0].
- `NO_OF_SHIFTS`, 8, number of LFSR steps applied to the seed before the word is serialized.
- `i_clk`  input  1  single clock; all state updates on the rising edge.
- `i_rst`  input  1  asynchronous, active-high reset.
- `i_seed`  input  NO_OF_BITS  seed; must be stable while `i_rst` is high; loaded during reset.
- `i_valid`  input  1  qualifies `i_data` on each rising edge.
- `i_data`  input  1  serial data bit, LSB of the word first.
- `o_word`  output  NO_OF_BITS  captured word; bit k is the k-th accepted bit.
- `o_done`  output  1  level: comparison complete; held until reset.
- `o_match`  output  1  valid while `o_done` is high; 1 when `o_word` equals the expected word.
- `o_overrun`  output  1  sticky: a valid bit arrived after the word was complete.

## Operation

Generator path:
- During reset, `r_exp` loads `i_seed` and `r_gen_cnt` loads 0.
- While `r_gen_cnt` < NO_OF_SHIFTS, each edge applies one step and increments `r_gen_cnt`.
  - Step: `r_exp` ← {fb, `r_exp`[N-1:1]}, where fb = XOR of `r_exp`[2:0].
- At `r_gen_cnt` = NO_OF_SHIFTS, `r_exp` freezes.

Capture path:
- Runs independently of the generator path; bits are accepted even while the generator is still stepping.
- On each edge with `i_valid`=1 and `r_bit_cnt` < NO_OF_BITS:
  - `r_word` ← {`i_data`, `r_word`[N-1:1]}
  - `r_bit_cnt` increments.
- After N accepted bits, `r_word` holds the word with its LSB in bit 0.

Compare state machine:
- States: GEN_RX → CHECK → DONE.
- GEN_RX: stays until `r_gen_cnt` = NO_OF_SHIFTS and `r_bit_cnt` = NO_OF_BITS are both true, then moves to CHECK.
- CHECK: lasts one cycle.
  - Registers `o_match` ← (`r_word` == `r_exp`).
  - Sets `o_done`=1.
  - Moves to DONE.
- DONE: terminal until reset; `o_word`, `o_match` and `o_done` are frozen.

Overrun:
- An edge with `i_valid`=1 and `r_bit_cnt` = NO_OF_BITS (in any state) sets `o_overrun`=1.
- The bit is discarded and `o_word` is unchanged.

Counter widths:
- `r_gen_cnt`: $clog2(NO_OF_SHIFTS+1).
- `r_bit_cnt`: $clog2(NO_OF_BITS+1).
- Neither counter wraps; both saturate at their terminal value.

Reset mid-operation:
- Any assertion of `i_rst` immediately clears all counters, the state and all outputs, and reloads `r_exp` from `i_seed`.
- Partial words are lost.

## Timing

- Reset values: `o_word`=0, `o_done`=0, `o_match`=0, `o_overrun`=0; state = GEN_RX.
- Edges are numbered from the first rising edge after `i_rst` deasserts (edge 1).
- `r_exp` is final after edge NO_OF_SHIFTS (edge 8 by default).
- The Nth bit accepted at edge T makes `r_bit_cnt` = N after T.
- Transition to CHECK occurs at edge max(T, NO_OF_SHIFTS) + 1.
- `o_done` and `o_match` become visible after edge max(T, NO_OF_SHIFTS) + 2.
- Paired with the generator (`o_valid` high out of edges 9–12):
  - Bits are sampled at edges 10–13.
  - `o_done` rises after edge 15.
- Gaps in `i_valid` are allowed and only delay T.
- No backpressure; every valid bit is accepted or counted as overrun in the same edge.
- A bit arriving on the same edge as the generator's final step is accepted normally; the two paths never conflict.
- `o_overrun` can rise in any state, including the same edge as the transition to CHECK.

## Test plan

- **Matching word, generator timing:** seed 4'b1001, bits 0,0,1,1 at edges 10–13 → expected 4'b1100; after edge 15 `o_done`=1, `o_word`=4'b1100, `o_match`=1, `o_overrun`=0.
- **Mismatch:** seed 4'b1001, bits 1,0,1,1 → `o_word`=4'b1101, `o_match`=0, `o_done`=1.
- **Early arrival:** seed 4'b1111, bits 1,1,1,1 at edges 1–4 → `o_done` does not rise before the generator finishes; it rises after edge 10 with `o_match`=1.
- **Gapped valid plus overrun:** seed 4'b0000, bits 0,0,0,0 with one idle cycle between each, then a 5th valid bit of 1 → `o_match`=1, `o_word`=4'b0000, `o_overrun`=1, `o_done` unaffected.
- **Reset mid-reception:** seed 4'b1001, 2 bits accepted, assert `i_rst` for 1 cycle, then send full correct sequence 0,0,1,1 → all outputs 0 during reset; final `o_match`=1, `o_word`=4'b1100.
- **Frozen after done:** after a completed compare, toggle `i_data` with `i_valid`=0 for 10 cycles → `o_word`, `o_match` and `o_done` unchanged.
